fx_pipe_scheduler: RTL

//  Shares one fixed-latency, fully pipelined 32-bit floating-point effect datapath
//  (e.g. the gain/exp/sub/sign distortion chain) between the left and right audio channels.
//  Per cycle: grants at most one channel (round-robin), drives the unit input and tags the

---
 rtl/fx_pipe_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fx_pipe_scheduler.sv
// rtl/fx_pipe_scheduler.sv - round-robin L/R scheduler for a shared fixed-latency effect datapath
module fx_pipe_scheduler #(
  parameter int LATENCY = 47,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          bypass,
  input  logic          l_req,
  input  logic [DW-1:0] l_data,
  output logic          l_ack,
  input  logic          r_req,
  input  logic [DW-1:0] r_data,
  output logic          r_ack,
  output logic [DW-1:0] unit_din,
  input  logic [DW-1:0] unit_dout,
  output logic [DW-1:0] l_out,
  output logic          l_valid,
  output logic [DW-1:0] r_out,
  output logic          r_valid,
  output logic          busy
);

  // The tag pipe is one stage deeper than LATENCY: the unit_din register
  // itself accounts for the extra cycle between grant and unit capture.
  localparam int DEPTH = LATENCY + 1;

  // ch: 0 = left, 1 = right
  typedef struct packed {
    logic v;
    logic ch;
  } tag_t;

  logic          r_run;
  logic          r_ptr;
  logic          r_l_pend;
  logic          r_r_pend;
  tag_t          r_tag [DEPTH];
  logic [DW-1:0] r_unit_din;
  logic [DW-1:0] r_l_out;
  logic [DW-1:0] r_r_out;
  logic          r_l_valid;
  logic          r_r_valid;

  logic          w_l_elig;
  logic          w_r_elig;
  logic          w_l_gnt;
  logic          w_r_gnt;
  logic          w_issue;
  logic          w_l_ret;
  logic          w_r_ret;
  logic          w_busy;
  tag_t          w_tag_in;
  tag_t          w_tag_out;

  // Eligibility, round-robin arbitration (r_ptr=0 favours left) and return decode
  always_comb begin
    w_l_elig    = r_run & l_req & ~r_l_pend;
    w_r_elig    = r_run & r_req & ~r_r_pend;
    w_l_gnt     = w_l_elig & (~w_r_elig | ~r_ptr);
    w_r_gnt     = w_r_elig & (~w_l_elig |  r_ptr);
    w_issue     = (w_l_gnt | w_r_gnt) & ~bypass;
    w_tag_in.v  = w_issue;
    w_tag_in.ch = w_r_gnt;
    w_tag_out   = r_tag[DEPTH-1];
    w_l_ret     = w_tag_out.v & ~w_tag_out.ch;
    w_r_ret     = w_tag_out.v &  w_tag_out.ch;
  end

  // Busy whenever any unit-path tag is still travelling
  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_busy = w_busy | r_tag[i].v;
    end
  end

  // Tag shift register; idle cycles push an invalid tag
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Run gate, RR pointer and per-channel outstanding flags
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_run    <= 1'b0;
      r_ptr    <= 1'b0;
      r_l_pend <= 1'b0;
      r_r_pend <= 1'b0;
    end else begin
      // r_run keeps acks off in the cycle in which aclr is released
      r_run <= 1'b1;
      if (w_l_elig & w_r_elig) begin
        r_ptr <= ~r_ptr;
      end
      // Bypass ops return on the next edge, so they never hold the channel
      r_l_pend <= (r_l_pend & ~w_l_ret) | (w_l_gnt & ~bypass);
      r_r_pend <= (r_r_pend & ~w_r_ret) | (w_r_gnt & ~bypass);
    end
  end

  // Unit operand register and per-channel result registers
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_unit_din <= '0;
      r_l_out    <= '0;
      r_r_out    <= '0;
      r_l_valid  <= 1'b0;
      r_r_valid  <= 1'b0;
    end else begin
      if (w_issue) begin
        r_unit_din <= w_r_gnt ? r_data : l_data;
      end
      // A unit return and a bypass grant can never hit the same channel at
      // once: the unit return implies the channel is still pending.
      r_l_valid <= w_l_ret | (w_l_gnt & bypass);
      r_r_valid <= w_r_ret | (w_r_gnt & bypass);
      if (w_l_ret) begin
        r_l_out <= unit_dout;
      end else if (w_l_gnt & bypass) begin
        r_l_out <= l_data;
      end
      if (w_r_ret) begin
        r_r_out <= unit_dout;
      end else if (w_r_gnt & bypass) begin
        r_r_out <= r_data;
      end
    end
  end

  assign l_ack    = w_l_gnt;
  assign r_ack    = w_r_gnt;
  assign unit_din = r_unit_din;
  assign l_out    = r_l_out;
  assign l_valid  = r_l_valid;
  assign r_out    = r_r_out;
  assign r_valid  = r_r_valid;
  assign busy     = w_busy;

endmodule
